// File: rtl/tff_counter.sv
// Loadable up/down modulo counter built as a chain of toggle cells with wrap and load override.
// Latency: Q and Wrap update one clock after qualifying inputs; Tc is combinational (zero latency).
// Backpressure: none; the counter advances on every enabled edge, and Tc feeds a cascaded stage's En.
module tff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_q,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic [WIDTH-1:0] w_mask;
    logic             w_carry;
    logic             w_term;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_wrap_val;
    logic [WIDTH-1:0] w_next;

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    always_comb begin
        w_mask  = '0;
        w_carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = w_carry;
            w_carry   = w_carry & (i_up ? r_q[i] : ~r_q[i]);
        end
    end

    assign w_term     = i_up ? (r_q == LP_MAX) : (r_q == '0);
    assign o_tc       = i_en & ~i_load & w_term;
    assign w_load_val = (i_din > LP_MAX) ? LP_MAX : i_din;
    assign w_wrap_val = i_up ? '0 : LP_MAX;

    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = w_load_val;
        end else if (i_en) begin
            w_next = w_term ? w_wrap_val : (r_q ^ w_mask);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_next;
            r_wrap <= o_tc;
        end
    end

    assign o_q    = r_q;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter: directed scenarios plus randomized traffic against a modulo-arithmetic model.
module tb_tff_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en, up, load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc, wrap;

    logic       c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

    int vectors = 0;
    int miscompares = 0;
    int mq = 0;
    bit mw = 1'b0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MODULUS(M)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_up(up), .i_load(load),
        .i_din(din), .o_q(q), .o_tc(tc), .o_wrap(wrap)
    );

    tff_counter #(.WIDTH(4), .MODULUS(M)) u_lo (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(c_en), .i_up(1'b1), .i_load(1'b0),
        .i_din(4'd0), .o_q(lo_q), .o_tc(lo_tc), .o_wrap(lo_wrap)
    );

    tff_counter #(.WIDTH(4), .MODULUS(M)) u_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(lo_tc), .i_up(1'b1), .i_load(1'b0),
        .i_din(4'd0), .o_q(hi_q), .o_tc(hi_tc), .o_wrap(hi_wrap)
    );

    function automatic bit exp_tc();
        return en && !load && ((up && mq == M - 1) || (!up && mq == 0));
    endfunction

    task automatic apply(input bit l, input bit e, input bit u, input int d);
        load = l;
        en   = e;
        up   = u;
        din  = 4'(d);
        #1;
    endtask

    // Advance one rising edge and update the model from the inputs present at that edge.
    task automatic edge_step();
        @(posedge clk);
        if (!rst_n) begin
            mq = 0;
            mw = 1'b0;
        end else if (load) begin
            mq = (int'(din) > M - 1) ? M - 1 : int'(din);
            mw = 1'b0;
        end else if (en) begin
            if (up) begin
                mw = (mq == M - 1);
                mq = (mq + 1) % M;
            end else begin
                mw = (mq == 0);
                mq = (mq + M - 1) % M;
            end
        end else begin
            mw = 1'b0;
        end
        #2;
    endtask

    task automatic test_reset();
        vectors++;
        if (q !== 4'd0) begin miscompares++; $display("FAIL reset_q: got %0d expected 0", q); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apply(0, 1, 1, 0);
            edge_step();
        end
        vectors++;
        if (q !== 4'd7) begin miscompares++; $display("FAIL reset_precount: got %0d expected 7", q); end
        #1 rst_n = 1'b0;
        mq = 0;
        mw = 1'b0;
        #1;
        vectors++;
        if (q !== 4'd0) begin miscompares++; $display("FAIL reset_async_q: got %0d expected 0", q); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_async_wrap: got %0b expected 0", wrap); end
        for (int i = 0; i < 3; i++) begin
            edge_step();
            vectors++;
            if (q !== 4'd0) begin miscompares++; $display("FAIL reset_hold_q: got %0d expected 0", q); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        for (int i = 0; i < 12; i++) begin
            apply(0, 1, 1, 0);
            vectors++;
            if (tc !== exp_tc()) begin miscompares++; $display("FAIL up_tc: got %0b expected %0b at q=%0d", tc, exp_tc(), mq); end
            edge_step();
            vectors++;
            if (q !== 4'(mq) || q !== 4'((i + 1) % M)) begin
                miscompares++; $display("FAIL up_q: got %0d expected %0d", q, (i + 1) % M);
            end
            vectors++;
            if (wrap !== mw || wrap !== (i == 9)) begin
                miscompares++; $display("FAIL up_wrap: got %0b expected %0b step %0d", wrap, mw, i);
            end
        end
    endtask

    task automatic test_down_wrap();
        int exp_seq [4] = '{1, 0, 9, 8};
        apply(1, 0, 0, 2);
        edge_step();
        vectors++;
        if (q !== 4'd2) begin miscompares++; $display("FAIL down_load: got %0d expected 2", q); end
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 0, 0);
            vectors++;
            if (tc !== exp_tc()) begin miscompares++; $display("FAIL down_tc: got %0b expected %0b", tc, exp_tc()); end
            edge_step();
            vectors++;
            if (q !== 4'(exp_seq[i])) begin miscompares++; $display("FAIL down_q: got %0d expected %0d", q, exp_seq[i]); end
            vectors++;
            if (wrap !== (i == 2)) begin miscompares++; $display("FAIL down_wrap: got %0b expected %0b step %0d", wrap, (i == 2), i); end
        end
    endtask

    task automatic test_load();
        apply(1, 1, 1, 5);
        edge_step();
        vectors++;
        if (q !== 4'd5 || wrap !== 1'b0) begin miscompares++; $display("FAIL load_5: got q=%0d wrap=%0b expected 5/0", q, wrap); end
        apply(1, 1, 1, 13);
        edge_step();
        vectors++;
        if (q !== 4'd9) begin miscompares++; $display("FAIL load_saturate: got %0d expected 9", q); end
        apply(1, 1, 1, 3);
        vectors++;
        if (tc !== 1'b0) begin miscompares++; $display("FAIL load_tc: got %0b expected 0", tc); end
        edge_step();
        vectors++;
        if (q !== 4'd3 || wrap !== 1'b0) begin miscompares++; $display("FAIL load_prio: got q=%0d wrap=%0b expected 3/0", q, wrap); end
    endtask

    task automatic test_hold_flip();
        apply(1, 0, 1, 4);
        edge_step();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 0);
            vectors++;
            if (tc !== 1'b0) begin miscompares++; $display("FAIL hold_tc: got %0b expected 0", tc); end
            edge_step();
            vectors++;
            if (q !== 4'd4) begin miscompares++; $display("FAIL hold_q: got %0d expected 4", q); end
        end
        apply(1, 0, 1, 0);
        edge_step();
        apply(0, 1, 1, 0);
        vectors++;
        if (tc !== 1'b0) begin miscompares++; $display("FAIL flip_tc_up: got %0b expected 0", tc); end
        apply(0, 1, 0, 0);
        vectors++;
        if (tc !== 1'b1) begin miscompares++; $display("FAIL flip_tc_down: got %0b expected 1", tc); end
        edge_step();
        vectors++;
        if (q !== 4'd9 || wrap !== 1'b1) begin miscompares++; $display("FAIL flip_wrap: got q=%0d wrap=%0b expected 9/1", q, wrap); end
        apply(0, 0, 0, 0);
        edge_step();
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL flip_pulse_width: got %0b expected 0", wrap); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(7) == 0), ($urandom_range(3) != 0), 1'($urandom), int'($urandom_range(15)));
            vectors++;
            if (tc !== exp_tc()) begin miscompares++; $display("FAIL rand_tc: got %0b expected %0b iter %0d", tc, exp_tc(), i); end
            edge_step();
            vectors++;
            if (q !== 4'(mq) || wrap !== mw) begin
                miscompares++; $display("FAIL rand_state: got q=%0d wrap=%0b expected %0d/%0b iter %0d", q, wrap, mq, mw, i);
            end
        end
    endtask

    task automatic test_cascade();
        int hi_pulses = 0;
        apply(0, 0, 1, 0);
        rst_n = 1'b0;
        mq = 0;
        mw = 1'b0;
        #1 rst_n = 1'b1;
        c_en = 1'b1;
        for (int n = 1; n <= 101; n++) begin
            if (n == 101) c_en = 1'b0;
            edge_step();
            if (hi_wrap) hi_pulses++;
            if (n <= 100) begin
                vectors++;
                if (lo_q !== 4'(n % 10) || hi_q !== 4'((n / 10) % 10)) begin
                    miscompares++; $display("FAIL cascade_q: got %0d,%0d expected %0d,%0d edge %0d", hi_q, lo_q, (n / 10) % 10, n % 10, n);
                end
            end
            vectors++;
            if (hi_wrap !== (n == 100)) begin miscompares++; $display("FAIL cascade_hi_wrap: got %0b expected %0b edge %0d", hi_wrap, (n == 100), n); end
            if (n == 99) begin
                vectors++;
                if (hi_q !== 4'd9 || lo_q !== 4'd9) begin miscompares++; $display("FAIL cascade_99: got %0d,%0d expected 9,9", hi_q, lo_q); end
            end
        end
        vectors++;
        if (hi_pulses !== 1) begin miscompares++; $display("FAIL cascade_pulses: got %0d expected 1", hi_pulses); end
    endtask

    initial begin
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        din  = 4'd0;
        c_en = 1'b0;
        #12;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_hold_flip();
        test_random();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
